fwd_hazard_ctrl: RTL

Forwarding and hazard controller for the 5-stage pipelined CPU.
- Keeps a shadow pipeline (EX, MEM, WB) of register-destination info for in-flight instructions.
- Drives the select inputs of the two EX-stage operand 3-to-1 muxes.
- Generates load-use stalls and data-memory wait freezes.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and is sampled by the PC and IF/ID write enables.

---
 rtl/fwd_hazard_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline: operand forwarding, load-use stalls, memory-wait freezes.
// Define HAZ_STALL_CNT_EN to add the stall_cnt_o counter of stall/freeze cycles.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int WAIT_MAX   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_mem_write_i,
    input  logic                  mem_ready_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_sel_o,
    output logic [1:0]            fwd_b_sel_o,
    output logic                  pc_write_o,
    output logic                  ifid_write_o,
    output logic                  idex_bubble_o,
    output logic                  pipe_freeze_o,
`ifdef HAZ_STALL_CNT_EN
    output logic [15:0]           stall_cnt_o,
`endif
    output logic                  mem_timeout_o
);

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_WAIT    = 1'b1;
    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    logic                  ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [REG_ADDR_W-1:0] ex_rd, ex_rs, ex_rt;
    logic                  mem_valid, mem_reg_write, mem_access;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_valid, wb_reg_write;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic [0:0] state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       timeout_q;
    logic       freeze, load_hit, stall;
    logic       mem_fwd_ok, wb_fwd_ok;

    // In WAIT the freeze tracks ready alone; the MEM shadow is held so it still names the access.
    always_comb begin
        freeze = 1'b0;
        if (state == ST_WAIT)
            freeze = !mem_ready_i;
        else
            freeze = mem_valid & mem_access & !mem_ready_i;
    end

    assign load_hit = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid_i &
                      ((ex_rd == id_rs_i) | (id_uses_rt_i & (ex_rd == id_rt_i)));
    assign stall    = load_hit & !flush_i & !freeze;

    assign pc_write_o    = !freeze & !stall;
    assign ifid_write_o  = !freeze & !stall;
    assign idex_bubble_o = stall;
    assign pipe_freeze_o = freeze;
    assign mem_timeout_o = timeout_q;

    assign mem_fwd_ok = mem_valid & mem_reg_write & (mem_rd != '0);
    assign wb_fwd_ok  = wb_valid & wb_reg_write & (wb_rd != '0);

    // The younger producer in MEM wins over WB when both target the same register.
    always_comb begin
        fwd_a_sel_o = 2'b00;
        fwd_b_sel_o = 2'b00;
        if (mem_fwd_ok && (mem_rd == ex_rs))
            fwd_a_sel_o = 2'b10;
        else if (wb_fwd_ok && (wb_rd == ex_rs))
            fwd_a_sel_o = 2'b01;
        if (mem_fwd_ok && (mem_rd == ex_rt))
            fwd_b_sel_o = 2'b10;
        else if (wb_fwd_ok && (wb_rd == ex_rt))
            fwd_b_sel_o = 2'b01;
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        if (state == ST_RUN) begin
            if (mem_valid && mem_access && !mem_ready_i) begin
                state_nxt    = ST_WAIT;
                wait_cnt_nxt = 8'd1;
            end
        end else begin
            if (mem_ready_i) begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = 8'd0;
            end else if (wait_cnt != 8'hFF) begin
                wait_cnt_nxt = wait_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_rd         <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            mem_valid     <= 1'b0;
            mem_reg_write <= 1'b0;
            mem_access    <= 1'b0;
            mem_rd        <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_rd         <= '0;
            state         <= ST_RUN;
            wait_cnt      <= 8'd0;
            timeout_q     <= 1'b0;
        end else begin
            if (!freeze) begin
                wb_valid      <= mem_valid;
                wb_reg_write  <= mem_reg_write;
                wb_rd         <= mem_rd;
                mem_valid     <= ex_valid;
                mem_reg_write <= ex_reg_write;
                mem_access    <= ex_mem_read | ex_mem_write;
                mem_rd        <= ex_rd;
                ex_valid      <= id_valid_i & !stall & !flush_i;
                ex_reg_write  <= id_reg_write_i;
                ex_mem_read   <= id_mem_read_i;
                ex_mem_write  <= id_mem_write_i;
                ex_rd         <= id_rd_i;
                ex_rs         <= id_rs_i;
                ex_rt         <= id_rt_i;
            end
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if ((state_nxt == ST_WAIT) && (wait_cnt_nxt == WAIT_LIMIT))
                timeout_q <= 1'b1;
        end
    end

`ifdef HAZ_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            stall_cnt_q <= 16'd0;
        else if ((stall || freeze) && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
